// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start detection, configurable 5-8 data bits,
// optional parity, one or two stop bits, FIFO push strobe, error pulses and idle timeout.
module uart_rx_sequencer #(
  parameter int unsigned OSR           = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic       RXen,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop_two,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       timeout_flag,
  output logic       busy
);

  localparam int unsigned ToW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [3:0] HalfTick = 4'(OSR / 2 - 1);
  localparam logic [3:0] LastTick = 4'(OSR - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic [1:0]     bits_q, bits_d;
  logic           pen_q, pen_d;
  logic           podd_q, podd_d;
  logic           two_q, two_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_arm_q, to_arm_d;
  logic           sync1_q, sync2_q;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           push_q, push_d;
  logic           ferr_out_q, ferr_out_d;
  logic           perr_out_q, perr_out_d;
  logic           ovr_q, ovr_d;
  logic           tout_q, tout_d;

  logic rx_s;
  logic tick_last;
  logic start_det;
  logic complete;

  assign rx_s      = sync2_q;
  assign tick_last = baud_tick && (cnt_q == LastTick);
  assign start_det = (state_q == StIdle) && RXen && baud_tick && !rx_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    bits_d     = bits_q;
    pen_d      = pen_q;
    podd_d     = podd_q;
    two_d      = two_q;
    to_cnt_d   = to_cnt_q;
    to_arm_d   = to_arm_q;
    rx_data_d  = rx_data_q;
    push_d     = 1'b0;
    ferr_out_d = 1'b0;
    perr_out_d = 1'b0;
    ovr_d      = 1'b0;
    tout_d     = 1'b0;
    complete   = 1'b0;

    if ((state_q == StIdle) && baud_tick && to_arm_q && !start_det) begin
      if (to_cnt_q == ToLast) begin
        tout_d   = 1'b1;
        to_arm_d = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d  = StStart;
          cnt_d    = '0;
          bit_d    = '0;
          shift_d  = '0;
          par_d    = 1'b0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          bits_d   = data_bits;
          pen_d    = parity_en;
          podd_d   = parity_odd;
          two_d    = stop_two;
          to_cnt_d = '0;
        end
      end
      StStart: begin
        if (baud_tick) begin
          if (cnt_q == HalfTick) begin
            cnt_d   = '0;
            state_d = rx_s ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick_last) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          par_d          = par_q ^ rx_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == (3'd4 + {1'b0, bits_q})) begin
            state_d = pen_q ? StParity : StStop1;
          end
        end else if (baud_tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StParity: begin
        if (tick_last) begin
          cnt_d   = '0;
          state_d = StStop1;
          if (rx_s != (par_q ^ podd_q)) begin
            perr_d = 1'b1;
          end
        end else if (baud_tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StStop1, StStop2: begin
        // A framing error holds the state until the next tick, which then completes
        if (baud_tick && ferr_q) begin
          complete = 1'b1;
        end else if (tick_last) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if ((state_q == StStop1) && two_q) begin
            state_d = StStop2;
          end else begin
            complete = 1'b1;
          end
        end else if (baud_tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      state_d    = StIdle;
      ferr_out_d = ferr_q;
      perr_out_d = perr_q;
      if (fifo_full) begin
        ovr_d = 1'b1;
      end else begin
        push_d    = 1'b1;
        rx_data_d = shift_q;
        to_cnt_d  = '0;
        to_arm_d  = 1'b1;
      end
    end

    // Disable aborts any frame silently; the timeout holds its place while disabled
    if (!RXen) begin
      state_d    = StIdle;
      cnt_d      = '0;
      rx_data_d  = rx_data_q;
      push_d     = 1'b0;
      ferr_out_d = 1'b0;
      perr_out_d = 1'b0;
      ovr_d      = 1'b0;
      tout_d     = 1'b0;
      to_cnt_d   = to_cnt_q;
      to_arm_d   = to_arm_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      bits_q     <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      two_q      <= 1'b0;
      to_cnt_q   <= '0;
      to_arm_q   <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_data_q  <= '0;
      push_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      bits_q     <= bits_d;
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      two_q      <= two_d;
      to_cnt_q   <= to_cnt_d;
      to_arm_q   <= to_arm_d;
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rx_data_q  <= rx_data_d;
      push_q     <= push_d;
      ferr_out_q <= ferr_out_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
      tout_q     <= tout_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_push      = push_q;
  assign frame_err    = ferr_out_q;
  assign parity_err   = perr_out_q;
  assign overrun_err  = ovr_q;
  assign timeout_flag = tout_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: directed frames push expected output events,
// a monitor pops and compares whenever the DUT pulses any output strobe.
module tb_uart_rx_sequencer;

  localparam int unsigned OSR = 16;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       RXen = 1'b1;
  logic [1:0] data_bits = 2'b11;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop_two = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_push, frame_err, parity_err, overrun_err, timeout_flag, busy;

  int checks = 0;
  int errors = 0;

  // {push, data, frame_err, parity_err, overrun_err, timeout_flag}
  typedef struct packed {
    logic       push;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       oerr;
    logic       tout;
  } ev_t;

  ev_t sb_q[$];

  uart_rx_sequencer #(.OSR(OSR), .TIMEOUT_TICKS(640)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .RXen        (RXen),
    .data_bits   (data_bits),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .stop_two    (stop_two),
    .fifo_full   (fifo_full),
    .rx_data     (rx_data),
    .rx_push     (rx_push),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    forever begin
      repeat (3) @(negedge PCLK);
      baud_tick = 1'b1;
      @(negedge PCLK);
      baud_tick = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk_ev(input logic p, input logic [7:0] d, input logic fe,
                                input logic pe, input logic oe, input logic to);
    ev_t e;
    e.push = p;
    e.data = d;
    e.ferr = fe;
    e.perr = pe;
    e.oerr = oe;
    e.tout = to;
    return e;
  endfunction

  always @(negedge PCLK) begin
    if (PRESETn && (rx_push || frame_err || parity_err || overrun_err || timeout_flag)) begin
      ev_t obs;
      ev_t exp_ev;
      obs = mk_ev(rx_push, rx_data, frame_err, parity_err, overrun_err, timeout_flag);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h, required no event", obs);
      end else begin
        exp_ev = sb_q.pop_front();
        if (obs !== exp_ev) begin
          errors++;
          $display("FAIL event: got %h, required %h", obs, exp_ev);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge PCLK);
      while (!baud_tick) @(posedge PCLK);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge PCLK);
    rxd = v;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic two, input logic stop2);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(1'b1);
    if (two) send_bit(stop2);
    @(negedge PCLK);
    rxd = 1'b1;
  endtask

  task automatic settle(input string name);
    wait_ticks(20);
    @(negedge PCLK);
    chk({name, "_drained"}, sb_q.size(), 0);
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge PCLK);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_strobes", {rx_push, frame_err, parity_err, overrun_err, timeout_flag}, 0);
    chk("reset_busy", busy, 1'b0);
    PRESETn = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    data_bits = 2'b11; parity_en = 1'b0; stop_two = 1'b0;
    sb_q.push_back(mk_ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    settle("8n1_a5");

    // 7E1 0x35 has four ones, so the correct even parity bit is 0; send 1
    data_bits = 2'b10; parity_en = 1'b1; parity_odd = 1'b0;
    sb_q.push_back(mk_ev(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0));
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    settle("7e1_perr");

    // 8N2 0x3C with second stop bit low
    data_bits = 2'b11; parity_en = 1'b0; stop_two = 1'b1;
    sb_q.push_back(mk_ev(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    settle("8n2_ferr");

    // Four-tick low glitch on idle line
    stop_two = 1'b0;
    @(negedge PCLK);
    rxd = 1'b0;
    wait_ticks(2);
    @(negedge PCLK);
    chk("glitch_start_busy", busy, 1'b1);
    wait_ticks(2);
    @(negedge PCLK);
    rxd = 1'b1;
    wait_ticks(12);
    @(negedge PCLK);
    chk("glitch_back_idle", busy, 1'b0);
    settle("glitch");

    // 5N1 0x1F into a full FIFO: overrun, rx_data keeps 0x3C
    data_bits = 2'b00; fifo_full = 1'b1;
    sb_q.push_back(mk_ev(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0));
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    settle("5n1_overrun");
    fifo_full = 1'b0;

    // RXen dropped mid-DATA
    data_bits = 2'b11;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge PCLK);
    chk("rxen_mid_busy", busy, 1'b1);
    RXen = 1'b0;
    @(negedge PCLK);
    chk("rxen_drop_idle", busy, 1'b0);
    rxd = 1'b1;
    wait_ticks(20);
    @(negedge PCLK);
    RXen = 1'b1;
    settle("rxen_drop");

    // Reset mid-frame discards the partial character
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_rx_data", rx_data, 8'h00);
    rxd = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    settle("midreset");

    // Frame then idle: exactly one timeout at tick 640 after the push
    sb_q.push_back(mk_ev(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk_ev(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ticks(600);
    @(negedge PCLK);
    chk("timeout_not_early", sb_q.size(), 1);
    wait_ticks(60);
    @(negedge PCLK);
    chk("timeout_fired", sb_q.size(), 0);
    wait_ticks(700);
    @(negedge PCLK);
    chk("timeout_once", sb_q.size(), 0);
    chk("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
